wb_dffram_port: RTL and testbench

- Wishbone classic slave that sits directly upstream of the 32-bit DFFRAM macro and drives its CLK/WE/EN/Di/A port.
- Converts single Wishbone transactions into one-cycle RAM accesses with registered address, data and byte enables.
- Captures the macro's registered read data before the macro zeroes it, and returns it with a single-cycle ack.
- Sits between the Caravel user-project Wishbone bus and one DFFRAM instance.

---
 rtl/wb_dffram_port.sv | 142 ++++++++++++++
 tb/tb_wb_dffram_port.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dffram_port.sv
// Wishbone classic slave driving one DFFRAM macro port: one RAM access per transaction.
// Define DFFRAM_RDREG_EN to add a read-data pipeline stage (one extra cycle of latency).
module wb_dffram_port #(
    parameter int unsigned COLS      = 1,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    localparam int unsigned A_WIDTH  = 8 + $clog2(COLS)
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               ram_clk,
    output logic               ram_en,
    output logic [3:0]         ram_we,
    output logic [31:0]        ram_di,
    output logic [A_WIDTH-1:0] ram_a,
    input  logic [31:0]        ram_do
);

`ifdef DFFRAM_RDREG_EN
    typedef enum logic [2:0] {StIdle, StIssue, StWait, StRdreg, StAck} state_e;
`else
    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;
`endif

    state_e              state_q, state_d;
    logic                en_q, en_d;
    logic [3:0]          we_q, we_d;
    logic [31:0]         di_q, di_d;
    logic [A_WIDTH-1:0]  a_q, a_d;
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic                wr_q, wr_d;
`ifdef DFFRAM_RDREG_EN
    logic [31:0]         pipe_q, pipe_d;
`endif

    logic hit;
    logic unused_adr;

    assign hit = wbs_cyc_i & wbs_stb_i &
                 (wbs_adr_i[31:A_WIDTH+2] == BASE_ADDR[31:A_WIDTH+2]);
    // Byte offset is meaningless on a 32-bit word RAM.
    assign unused_adr = ^wbs_adr_i[1:0];

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        we_d    = we_q;
        di_d    = di_q;
        a_d     = a_q;
        ack_d   = ack_q;
        dat_d   = dat_q;
        wr_d    = wr_q;
`ifdef DFFRAM_RDREG_EN
        pipe_d  = pipe_q;
`endif
        case (state_q)
            StIdle: begin
                if (hit) begin
                    en_d    = 1'b1;
                    a_d     = wbs_adr_i[A_WIDTH+1:2];
                    di_d    = wbs_dat_i;
                    we_d    = wbs_we_i ? wbs_sel_i : 4'b0;
                    wr_d    = wbs_we_i;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                en_d    = 1'b0;
                we_d    = 4'b0;
                state_d = StWait;
            end
`ifdef DFFRAM_RDREG_EN
            StWait: begin
                pipe_d  = ram_do;
                state_d = StRdreg;
            end
            StRdreg: begin
                if (!wr_q) dat_d = pipe_q;
                ack_d   = wbs_cyc_i;
                state_d = StAck;
            end
`else
            // Macro output is only valid for this one cycle before it is zeroed.
            StWait: begin
                if (!wr_q) dat_d = ram_do;
                ack_d   = wbs_cyc_i;
                state_d = StAck;
            end
`endif
            StAck: begin
                ack_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            en_q    <= 1'b0;
            we_q    <= 4'b0;
            di_q    <= 32'b0;
            a_q     <= '0;
            ack_q   <= 1'b0;
            dat_q   <= 32'b0;
            wr_q    <= 1'b0;
`ifdef DFFRAM_RDREG_EN
            pipe_q  <= 32'b0;
`endif
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            we_q    <= we_d;
            di_q    <= di_d;
            a_q     <= a_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            wr_q    <= wr_d;
`ifdef DFFRAM_RDREG_EN
            pipe_q  <= pipe_d;
`endif
        end
    end

    assign ram_clk   = wb_clk_i;
    assign ram_en    = en_q;
    assign ram_we    = we_q;
    assign ram_di    = di_q;
    assign ram_a     = a_q;
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_dffram_port.sv
// Bench for wb_dffram_port: vector table plus multi-cycle sequences, with a DFFRAM behavioural model.
module tb_wb_dffram_port;

`ifdef DFFRAM_RDREG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk, rst, cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic        ram_clk, ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_di, ram_do;
    logic [7:0]  ram_a;
    logic [31:0] mem [256];
    logic [95:0] all_out;

    int          total = 0;
    int          bad = 0;
    logic [31:0] sb[$];
    logic [31:0] last_rd;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        hit;
        logic [7:0]  ea;
        logic [3:0]  ewe;
        logic [31:0] erd;
    } vec_t;
    vec_t vecs[10];

    wb_dffram_port dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_w),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_r),
        .ram_clk   (ram_clk),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_di    (ram_di),
        .ram_a     (ram_a),
        .ram_do    (ram_do)
    );

    assign all_out = {18'b0, ack, dat_r, ram_en, ram_we, ram_di, ram_a};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DFFRAM model: registered output, zeroed on any edge without EN.
    always @(posedge ram_clk) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) mem[ram_a][8*i +: 8] <= ram_di[8*i +: 8];
            ram_do <= mem[ram_a];
        end else begin
            ram_do <= 32'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        total++;
        if (all_out !== 96'b0) begin
            bad++;
            $display("FAIL %s actual=%h required=0", name, all_out);
        end
    endtask

    task automatic pop_check(input string name);
        logic [31:0] e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s_unexpected_read actual=%h required=none", name, dat_r);
        end else begin
            e = sb.pop_front();
            if (dat_r !== e) begin
                bad++;
                $display("FAIL %s_rdata actual=%h required=%h", name, dat_r, e);
            end
        end
    endtask

    task automatic xfer(input string name, input vec_t v);
        int acks, ens, lat;
        acks = 0; ens = 0; lat = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = v.w; adr = v.a; sel = v.s; dat_w = v.d;
        if (v.hit && !v.w) sb.push_back(v.erd);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ram_en) begin
                ens++;
                chk({name, "_ram_a"}, 32'(ram_a), 32'(v.ea));
                chk({name, "_ram_we"}, 32'(ram_we), 32'(v.ewe));
                if (v.w) chk({name, "_ram_di"}, ram_di, v.d);
            end
            if (ack) begin
                acks++;
                if (acks == 1) lat = k;
                if (!v.w) pop_check(name);
                cyc = 1'b0; stb = 1'b0;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        chk({name, "_acks"}, 32'(acks), v.hit ? 32'd1 : 32'd0);
        chk({name, "_en_cycles"}, 32'(ens), v.hit ? 32'd1 : 32'd0);
        if (v.hit) chk({name, "_latency"}, 32'(lat), 32'(LAT));
        if (v.hit && !v.w) last_rd = v.erd;
        chk({name, "_dat_hold"}, dat_r, last_rd);
    endtask

    // ram_en must never be high on two consecutive cycles.
    initial begin
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en = 1'b0;
            end else begin
                if (ram_en) begin
                    total++;
                    if (prev_en) begin
                        bad++;
                        $display("FAIL en_single_cycle actual=2+ required=1");
                    end
                end
                prev_en = ram_en;
            end
        end
    end

    initial begin
        int acks, ens, lat;
        vec_t v;
        vecs[0] = '{1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, 1'b1, 8'h04, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 32'h3000_0010, 4'hF, 32'h0,         1'b1, 8'h04, 4'h0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h3000_0010, 4'h2, 32'h0000_5500, 1'b1, 8'h04, 4'h2, 32'h0};
        vecs[3] = '{1'b0, 32'h3000_0010, 4'hF, 32'h0,         1'b1, 8'h04, 4'h0, 32'hDEAD_55EF};
        vecs[4] = '{1'b1, 32'h3000_03FC, 4'hF, 32'hCAFE_F00D, 1'b1, 8'hFF, 4'hF, 32'h0};
        vecs[5] = '{1'b0, 32'h3000_03FF, 4'h0, 32'h0,         1'b1, 8'hFF, 4'h0, 32'hCAFE_F00D};
        vecs[6] = '{1'b1, 32'h3100_0000, 4'hF, 32'h0BAD_F00D, 1'b0, 8'h00, 4'h0, 32'h0};
        vecs[7] = '{1'b0, 32'h3000_0400, 4'hF, 32'h0,         1'b0, 8'h00, 4'h0, 32'h0};
        vecs[8] = '{1'b1, 32'h3000_0010, 4'h0, 32'hFFFF_FFFF, 1'b1, 8'h04, 4'h0, 32'h0};
        vecs[9] = '{1'b0, 32'h3000_0010, 4'hF, 32'h0,         1'b1, 8'h04, 4'h0, 32'hDEAD_55EF};

        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; dat_w = 32'h0; last_rd = 32'h0;

        // Async reset asserted between edges must clear outputs at once.
        #1 rst = 1'b1;
        #1 chk_zero("rst_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_zero("rst_idle");
        end

        for (int i = 0; i < 10; i++) xfer($sformatf("vec%0d", i), vecs[i]);

        // Back-to-back: stb held through the ack cycle, then a new read without dropping cyc.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0040; sel = 4'hF; dat_w = 32'h1111_2222;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ack && lat == 0) lat = k;
            if (lat != 0) break;
        end
        chk("b2b_wr_latency", 32'(lat), 32'(LAT));
        @(negedge clk);
        chk("b2b_ack_drop", 32'(ack), 32'd0);
        chk("b2b_no_reissue", 32'(ram_en), 32'd0);
        we = 1'b0; adr = 32'h3000_03FC;
        sb.push_back(32'hCAFE_F00D);
        acks = 0; ens = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ram_en) begin
                ens++;
                chk("b2b_ram_a", 32'(ram_a), 32'h0000_00FF);
            end
            if (ack) begin
                acks++;
                pop_check("b2b_rd");
                cyc = 1'b0; stb = 1'b0;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        chk("b2b_rd_acks", 32'(acks), 32'd1);
        chk("b2b_rd_en", 32'(ens), 32'd1);
        last_rd = 32'hCAFE_F00D;
        v = '{1'b0, 32'h3000_0040, 4'hF, 32'h0, 1'b1, 8'h10, 4'h0, 32'h1111_2222};
        xfer("b2b_rdback", v);

        // Abort: cyc drops right after the access is issued; the write must still land.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_001C; sel = 4'hF; dat_w = 32'h1234_5678;
        @(negedge clk);
        chk("abort_en", 32'(ram_en), 32'd1);
        cyc = 1'b0; stb = 1'b0;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("abort_no_ack", 32'(acks), 32'd0);
        chk("abort_dat_hold", dat_r, last_rd);
        v = '{1'b0, 32'h3000_001C, 4'hF, 32'h0, 1'b1, 8'h07, 4'h0, 32'h1234_5678};
        xfer("abort_rdback", v);

        // Reset mid-access kills ram_en and clears read data immediately.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0080; sel = 4'hF; dat_w = 32'hAAAA_5555;
        @(negedge clk);
        chk("midrst_en", 32'(ram_en), 32'd1);
        #2 rst = 1'b1;
        #1 chk_zero("midrst_async");
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk_zero("midrst_held");
        rst = 1'b0;
        last_rd = 32'h0;
        v = '{1'b0, 32'h3000_0010, 4'hF, 32'h0, 1'b1, 8'h04, 4'h0, 32'hDEAD_55EF};
        xfer("midrst_rdback", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
